neuron_act_stage: RTL

//  Downstream stage of the MAC unit: counts accumulation strobes for one neuron,

---
 rtl/neuron_act_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/neuron_act_stage.sv
// Neuron activation stage: counts MAC strobes, waits for the MAC pipeline to drain,
// adds bias, rescales, saturates and hands the result on via valid/ready.
// Build option: define NEURON_ACT_BIAS_EN to add the bias; otherwise the bias port is ignored.
module neuron_act_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int N_INPUTS    = 4,
  parameter int MAC_LATENCY = 2,
  parameter int SHIFT       = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mac_en_in,
  input  logic [2*DATA_WIDTH:0]   mac_sum,
  input  logic [2*DATA_WIDTH:0]   bias,
  output logic                    stall,
  output logic                    acc_clear,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_flag,
  output logic                    overrun_err
);

  // state | meaning
  // ACCUM | counting MAC strobes, upstream free to run
  // DRAIN | last strobe seen, waiting MAC_LATENCY cycles for mac_sum to settle
  // PROC  | bias add, rescale, saturate
  // HOLD  | result presented, waiting for out_ready

  localparam int SW    = 2*DATA_WIDTH + 1;
  localparam int XW    = SW + 1;
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int DLY_W = $clog2(MAC_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(MAC_LATENCY);

  typedef enum logic [1:0] {ACCUM, DRAIN, PROC, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic                 stall_d, valid_d, clear_d, overrun_d;
  logic                 cap_en, res_en;
  logic [SW-1:0]        sum_q;
  logic [SW-1:0]        bias_eff;
  logic [XW-1:0]        total;
  logic [XW-1:0]        shifted;
  logic                 sat_w;
  logic [DATA_WIDTH-1:0] data_w;

`ifdef NEURON_ACT_BIAS_EN
  logic [SW-1:0] bias_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       bias_q <= '0;
    else if (cap_en) bias_q <= bias;
  end

  assign bias_eff = bias_q;
`else
  // Bias deliberately masked off; the port stays for a uniform interface.
  assign bias_eff = bias & {SW{1'b0}};
`endif

  assign total   = {1'b0, sum_q} + {1'b0, bias_eff};
  assign shifted = total >> SHIFT;
  assign sat_w   = |shifted[XW-1:DATA_WIDTH];
  assign data_w  = sat_w ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      dly_q       <= '0;
      stall       <= 1'b0;
      out_valid   <= 1'b0;
      acc_clear   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      stall       <= stall_d;
      out_valid   <= valid_d;
      acc_clear   <= clear_d;
      overrun_err <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q    <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (cap_en) sum_q <= mac_sum;
      if (res_en) begin
        out_data <= data_w;
        sat_flag <= sat_w;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    stall_d   = stall;
    valid_d   = out_valid;
    clear_d   = 1'b0;
    cap_en    = 1'b0;
    res_en    = 1'b0;
    // Any strobe while stalled is an upstream protocol violation.
    overrun_d = overrun_err | (mac_en_in & stall);
    case (state_q)
      ACCUM: begin
        if (mac_en_in) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
            dly_d   = DLY_LOAD;
            stall_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dly_q == '0) begin
          cap_en  = 1'b1;
          state_d = PROC;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      PROC: begin
        res_en  = 1'b1;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          clear_d = 1'b1;
          stall_d = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule
